// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux: AHB-Lite data-phase response mux for six slaves plus default ERROR slave (HCLK/HRESETn, P*_HSEL/HREADYOUT/HRESP/HRDATA in, HREADYOUT/HRESP/HRDATA out)
module ahblite_slave_mux #(
  parameter logic [5:0]  PORT_EN       = 6'b111111,
  parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P5_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P5_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  input  logic        P5_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  input  logic [31:0] P5_HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_e;
  ds_e              ds_q, ds_d;
  logic [5:0]       sel_q, sel_d, hsel, pick, ready, resp;
  logic [5:0][31:0] rdata;
  logic             def_sel, mux_ready, mux_resp;
  logic [31:0]      mux_rdata;
  assign hsel  = {P5_HSEL, P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
  assign ready = {P5_HREADYOUT, P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
  assign resp  = {P5_HRESP, P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
  assign rdata = {P5_HRDATA, P4_HRDATA, P3_HRDATA, P2_HRDATA, P1_HRDATA, P0_HRDATA};
  assign pick  = hsel & (~hsel + 6'd1);
  always_comb begin
    def_sel = ~|hsel & (HTRANS inside {2'b10, 2'b11});
    sel_d   = HREADY ? pick : sel_q;
    ds_d    = ds_q == DS_ERR1 ? DS_ERR2 : (HREADY && def_sel) ? DS_ERR1 : DS_IDLE;
  end
  always_comb begin
    mux_ready = 1'b1;
    mux_resp  = 1'b0;
    mux_rdata = DEFAULT_RDATA;
    for (int i = 0; i < 6; i++) begin
      mux_ready = sel_q[i] ? ready[i] : mux_ready;
      mux_resp  = sel_q[i] ? resp[i]  : mux_resp;
      mux_rdata = sel_q[i] ? rdata[i] : mux_rdata;
    end
  end
  assign HREADYOUT = ds_q == DS_ERR1 ? 1'b0 : ds_q == DS_ERR2 ? 1'b1 : mux_ready;
  assign HRESP     = ds_q != DS_IDLE ? 1'b1 : mux_resp;
  assign HRDATA    = ds_q != DS_IDLE ? DEFAULT_RDATA : mux_rdata;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sel_q <= '0;
      ds_q  <= DS_IDLE;
    end else begin
      sel_q <= sel_d;
      ds_q  <= ds_d;
    end
endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb_ahblite_slave_mux: table-driven scoreboard bench for ahblite_slave_mux
module tb_ahblite_slave_mux;
  localparam logic [5:0] F = 6'h3f;
  typedef struct {
    logic hr; logic [1:0] tr; logic [5:0] hs, ry, rs;
    logic e_ry, e_rs; logic [31:0] e_rd;
  } vec_t;
  typedef struct {int id; logic e_ry, e_rs; logic [31:0] e_rd; string nm;} exp_t;
  logic clk = 0, rst_n = 0, hready = 1;
  logic [1:0] htrans = 0;
  logic [5:0] hsel = 0, ry = F, rs = 0;
  logic [5:0][31:0] rd;
  logic a_ry, a_rs, b_ry, b_rs;
  logic [31:0] a_rd, b_rd;
  exp_t sbq[$];
  vec_t tbl[$];
  int checks = 0, failures = 0;
  assign rd = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1000};
  always #5 clk = ~clk;
  ahblite_slave_mux u0 (
    .HCLK(clk), .HRESETn(rst_n), .HREADY(hready), .HTRANS(htrans),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]),
    .P0_HREADYOUT(ry[0]), .P1_HREADYOUT(ry[1]), .P2_HREADYOUT(ry[2]), .P3_HREADYOUT(ry[3]), .P4_HREADYOUT(ry[4]), .P5_HREADYOUT(ry[5]),
    .P0_HRESP(rs[0]), .P1_HRESP(rs[1]), .P2_HRESP(rs[2]), .P3_HRESP(rs[3]), .P4_HRESP(rs[4]), .P5_HRESP(rs[5]),
    .P0_HRDATA(rd[0]), .P1_HRDATA(rd[1]), .P2_HRDATA(rd[2]), .P3_HRDATA(rd[3]), .P4_HRDATA(rd[4]), .P5_HRDATA(rd[5]),
    .HREADYOUT(a_ry), .HRESP(a_rs), .HRDATA(a_rd)
  );
  ahblite_slave_mux #(.PORT_EN(6'b101111)) u1 (
    .HCLK(clk), .HRESETn(rst_n), .HREADY(hready), .HTRANS(htrans),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]),
    .P0_HREADYOUT(ry[0]), .P1_HREADYOUT(ry[1]), .P2_HREADYOUT(ry[2]), .P3_HREADYOUT(ry[3]), .P4_HREADYOUT(ry[4]), .P5_HREADYOUT(ry[5]),
    .P0_HRESP(rs[0]), .P1_HRESP(rs[1]), .P2_HRESP(rs[2]), .P3_HRESP(rs[3]), .P4_HRESP(rs[4]), .P5_HRESP(rs[5]),
    .P0_HRDATA(rd[0]), .P1_HRDATA(rd[1]), .P2_HRDATA(rd[2]), .P3_HRDATA(rd[3]), .P4_HRDATA(rd[4]), .P5_HRDATA(rd[5]),
    .HREADYOUT(b_ry), .HRESP(b_rs), .HRDATA(b_rd)
  );
  task automatic chk(input string nm, input logic g_ry, g_rs, input logic [31:0] g_rd,
                     input logic e_ry, e_rs, input logic [31:0] e_rd);
    checks++;
    if ({g_ry, g_rs, g_rd} !== {e_ry, e_rs, e_rd}) begin
      failures++;
      $display("FAIL %s: got hreadyout=%b hresp=%b hrdata=%h, want hreadyout=%b hresp=%b hrdata=%h",
               nm, g_ry, g_rs, g_rd, e_ry, e_rs, e_rd);
    end
  endtask
  always @(negedge clk)
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.id == 0) chk(e.nm, a_ry, a_rs, a_rd, e.e_ry, e.e_rs, e.e_rd);
      else chk(e.nm, b_ry, b_rs, b_rd, e.e_ry, e.e_rs, e.e_rd);
    end
  task automatic drive(input int id, input string nm, input vec_t v);
    hready = v.hr;
    htrans = v.tr;
    hsel   = v.hs;
    ry     = v.ry;
    rs     = v.rs;
    sbq.push_back('{id, v.e_ry, v.e_rs, v.e_rd, nm});
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd2, 6'b000010, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'hDEADBEEF});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd2, 6'b001000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{0, 2'd2, 6'b010000, 6'b110111, 6'b0, 0, 0, 32'h33333333});
    tbl.push_back('{0, 2'd2, 6'b010000, 6'b110111, 6'b0, 0, 0, 32'h33333333});
    tbl.push_back('{1, 2'd2, 6'b010000, F, 6'b0, 1, 0, 32'h33333333});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b010000, 1, 1, 32'h44444444});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd2, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{0, 2'd0, 6'b000000, F, 6'b0, 0, 1, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 1, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd2, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{0, 2'd3, 6'b000000, F, 6'b0, 0, 1, 32'h0});
    tbl.push_back('{1, 2'd3, 6'b000000, F, 6'b0, 1, 1, 32'h0});
    tbl.push_back('{0, 2'd0, 6'b000000, F, 6'b0, 0, 1, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 1, 32'h0});
    tbl.push_back('{1, 2'd1, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd2, 6'b100110, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{0, 2'd0, 6'b000000, 6'b111101, 6'b0, 0, 0, 32'hDEADBEEF});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'hDEADBEEF});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd2, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{0, 2'd0, 6'b000000, F, 6'b0, 0, 1, 32'h0});
    tbl.push_back('{1, 2'd2, 6'b100000, F, 6'b0, 1, 1, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h55555555});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000100, F, 6'b0, 1, 0, 32'h0});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h22222222});
    tbl.push_back('{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    chk("reset_u0", a_ry, a_rs, a_rd, 1, 0, 32'h0);
    chk("reset_u1", b_ry, b_rs, b_rd, 1, 0, 32'h0);
    rst_n = 1;
    foreach (tbl[i]) drive(0, $sformatf("vec%0d", i), tbl[i]);
    drive(1, "pen_addr", '{1, 2'd2, 6'b010000, F, 6'b0, 1, 0, 32'h0});
    drive(1, "pen_err1", '{0, 2'd0, 6'b000000, F, 6'b010000, 0, 1, 32'h0});
    drive(1, "pen_err2", '{1, 2'd0, 6'b000000, F, 6'b010000, 1, 1, 32'h0});
    drive(1, "pen_okay", '{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    drive(0, "rst_addr", '{1, 2'd2, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    hready = 0;
    htrans = 2'd0;
    sbq.push_back('{0, 1'b0, 1'b1, 32'h0, "rst_err1"});
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk("rst_async", a_ry, a_rs, a_rd, 1, 0, 32'h0);
    hready = 1;
    @(posedge clk);
    #1 rst_n = 1;
    drive(0, "rst_idle0", '{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    drive(0, "rst_idle1", '{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h0});
    drive(0, "rst_p0addr", '{1, 2'd2, 6'b000001, F, 6'b0, 1, 0, 32'h0});
    drive(0, "rst_p0data", '{1, 2'd0, 6'b000000, F, 6'b0, 1, 0, 32'h00001000});
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
